// File: rtl/ram_copy_engine.sv
// ram_copy_engine
//
// Runs block operations on a RAM with one read port and one write port,
// issuing at most one read and one write per cycle:
//   - copy : moves `length` words from srcAddress to dstAddress. Overlapping
//            ranges are safe (memmove semantics).
//   - fill : writes `length` copies of fillValue starting at dstAddress.
//
// Ports
//   clk, resetN            clock and synchronous active-low reset
//   start, mode            request pulse (taken in IDLE only); 0 = copy, 1 = fill
//   srcAddress, dstAddress source and destination base addresses
//   length, fillValue      word count and fill constant
//   busy, done, error      status: busy in RUN/DRAIN; done pulses once per request;
//                          error pulses with done when a request is rejected
//   wordsDone              number of writes in the current or last operation
//   readAddress/Enable     RAM read port request
//   readValue              RAM read data, combinational from readAddress
//   writeAddress/Value/Enable  RAM write port; the RAM commits on the next edge
//
// All outputs are registered. Any output that is not being asserted is driven to 0.
module ram_copy_engine #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] srcAddress,
    input  logic [ADDR_W-1:0] dstAddress,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] fillValue,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] wordsDone,
    output logic [ADDR_W-1:0] readAddress,
    output logic              readEnable,
    input  logic [DATA_W-1:0] readValue,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [DATA_W-1:0] writeValue,
    output logic              writeEnable
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_t state_q, state_d;

    // Request parameters, latched when a request is accepted.
    logic              mode_q,  mode_d;
    logic              desc_q,  desc_d;
    logic [ADDR_W-1:0] src_q,   src_d;
    logic [ADDR_W-1:0] dst_q,   dst_d;
    logic [ADDR_W-1:0] len_q,   len_d;
    logic [DATA_W-1:0] fill_q,  fill_d;
    // Index of the word handled by the current RUN cycle.
    logic [ADDR_W-1:0] idx_q,   idx_d;

    // Registered outputs.
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic              re_q,    re_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    // In copy mode this register also acts as the data register: it captures
    // readValue at the same edge that schedules the matching write.
    logic [DATA_W-1:0] wval_q,  wval_d;

    // Range check and direction, evaluated on the raw request inputs.
    logic [ADDR_W:0] dst_end;
    logic [ADDR_W:0] src_end;
    logic            req_err;
    logic            req_desc;

    always_comb begin
        dst_end  = {1'b0, dstAddress} + {1'b0, length};
        src_end  = {1'b0, srcAddress} + {1'b0, length};
        req_err  = (dst_end > DEPTH_EXT) || (!mode && (src_end > DEPTH_EXT));
        // Descending only when the destination starts inside the source range
        // above its base; copying forward would then overwrite unread words.
        req_desc = !mode && (dstAddress > srcAddress) && ({1'b0, dstAddress} < src_end);
    end

    // Address of word i of a block: ascending base+i, descending base+L-1-i.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] len,
        input logic [ADDR_W-1:0] i,
        input logic              desc
    );
        word_addr = desc ? (base + len - ONE - i) : (base + i);
    endfunction

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        desc_d  = desc_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        idx_d   = idx_q;

        busy_d  = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        re_d    = 1'b0;
        raddr_d = '0;
        we_d    = 1'b0;
        waddr_d = '0;
        wval_d  = '0;
        // Count the write being committed at this edge.
        words_d = we_q ? (words_q + ONE) : words_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    desc_d  = req_desc;
                    src_d   = srcAddress;
                    dst_d   = dstAddress;
                    len_d   = length;
                    fill_d  = fillValue;
                    idx_d   = '0;
                    words_d = '0;
                    if (req_err || (length == '0)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        error_d = req_err;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        if (mode) begin
                            we_d    = 1'b1;
                            waddr_d = dstAddress;
                            wval_d  = fillValue;
                        end else begin
                            re_d    = 1'b1;
                            raddr_d = req_desc ? (srcAddress + length - ONE) : srcAddress;
                        end
                    end
                end
            end

            RUN: begin
                busy_d = 1'b1;
                if (!mode_q) begin
                    // The word read this cycle is written next cycle.
                    we_d    = 1'b1;
                    waddr_d = word_addr(dst_q, len_q, idx_q, desc_q);
                    wval_d  = readValue;
                    if (idx_q == len_q - ONE) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d   = idx_q + ONE;
                        re_d    = 1'b1;
                        raddr_d = word_addr(src_q, len_q, idx_q + ONE, desc_q);
                    end
                end else begin
                    if (idx_q == len_q - ONE) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + ONE;
                        we_d    = 1'b1;
                        waddr_d = word_addr(dst_q, len_q, idx_q + ONE, desc_q);
                        wval_d  = fill_q;
                    end
                end
            end

            DRAIN: begin
                state_d = DONE;
                done_d  = 1'b1;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            desc_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            words_q <= '0;
            re_q    <= 1'b0;
            raddr_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wval_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            desc_q  <= desc_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            words_q <= words_d;
            re_q    <= re_d;
            raddr_q <= raddr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wval_q  <= wval_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign wordsDone    = words_q;
    assign readEnable   = re_q;
    assign readAddress  = raddr_q;
    assign writeEnable  = we_q;
    assign writeAddress = waddr_q;
    assign writeValue   = wval_q;

endmodule
